// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
// Imported by the fetch stage, its PC generator and its handshake interface.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DONE  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // ADD XZR,XZR,XZR: a harmless bubble for decode.
    localparam logic [31:0] NOP = 32'h8b1f03ff;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_if.sv
// IF/ID valid/ready handshake between the fetch stage and decode.
// The fetch stage is the master, decode is the slave.
interface fetch_if #(
    parameter int PC_W = 64
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter, next-PC selection and the RUN/DONE/FAULT controller.
// Produces the capture strobe and the flush request for the IF/ID register.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 64,
    parameter int              IMEM_DEPTH = 19,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            slot_free,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic            capture,
    output logic            flush,
    output fetch_state_t    state,
    output logic            fetch_done,
    output logic            fetch_fault,
    output logic [PC_W-1:0] fault_pc
);

    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] fault_d;
    logic [PC_W-3:0] widx;
    logic            in_range;
    logic            aligned;
    logic            want;

    // Range check on the full word index so a wrapped PC cannot alias ROM.
    always_comb begin
        widx     = pc[PC_W-1:2];
        in_range = widx < (PC_W-2)'(IMEM_DEPTH);
        aligned  = redirect_pc[1:0] == 2'b00;
        want     = fetch_en && slot_free && !redirect_valid;
        capture  = (state == RUN) && want && in_range;
        flush    = redirect_valid && (state != FAULT);
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        fault_d = fault_pc;
        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    if (aligned) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = FAULT;
                        fault_d = redirect_pc;
                    end
                end else if (want && !in_range) begin
                    state_d = DONE;
                end else if (capture) begin
                    pc_d = pc + PC_W'(INSTR_BYTES);
                end
            end
            DONE: begin
                if (redirect_valid) begin
                    if (aligned) begin
                        state_d = RUN;
                        pc_d    = redirect_pc;
                    end else begin
                        state_d = FAULT;
                        fault_d = redirect_pc;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            fault_pc <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            fault_pc <= fault_d;
        end
    end

    assign fetch_done  = (state == DONE);
    assign fetch_fault = (state == FAULT);

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: drives the ROM address and holds the
// IF/ID register with its valid/ready handshake and accept counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 64,
    parameter int              IMEM_AW    = 6,
    parameter int              IMEM_DEPTH = 19,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    fetch_if.master            ifid,
    output logic               fetch_done,
    output logic               fetch_fault,
    output logic [PC_W-1:0]    fault_pc,
    output logic [31:0]        instr_count
);

    logic [PC_W-1:0] pc;
    logic            capture;
    logic            flush;
    logic            slot_free;
    logic            accept;
    fetch_state_t    state;

    assign slot_free = !ifid.if_valid || ifid.if_ready;
    assign accept    = ifid.if_valid && ifid.if_ready;
    assign imem_addr = pc[IMEM_AW+1:2];

    fetch_pc_gen #(
        .PC_W       (PC_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .slot_free      (slot_free),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .capture        (capture),
        .flush          (flush),
        .state          (state),
        .fetch_done     (fetch_done),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    // A flush drops the held word even if decode has not taken it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid.if_valid <= 1'b0;
            ifid.if_instr <= '0;
            ifid.if_pc    <= '0;
        end else if (flush) begin
            ifid.if_valid <= 1'b0;
        end else if (capture) begin
            ifid.if_valid <= 1'b1;
            ifid.if_instr <= imem_q;
            ifid.if_pc    <= pc;
        end else if (accept) begin
            ifid.if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (accept) begin
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural ROM.
// Each scenario task drives stimulus and checks its own expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        fetch_done;
    logic        fetch_fault;
    logic [63:0] fault_pc;
    logic [31:0] instr_count;
    logic [31:0] rom [64];

    int tests = 0;
    int fails = 0;

    fetch_if #(.PC_W(64)) ifid ();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid           (ifid.master),
        .fetch_done     (fetch_done),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset = 1'b0;
        fetch_en = 1'b0;
        ifid.if_ready = 1'b1;
        redirect_valid = 1'b0;
        step();
        reset = 1'b1;
        fetch_en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifid.if_ready = 1'b1;
        #3;
        tests++;
        if ({ifid.if_valid, ifid.if_instr, ifid.if_pc} !== 97'h0) begin
            fails++;
            $display("FAIL reset_ifid: got v=%b i=%h pc=%h want 0",
                     ifid.if_valid, ifid.if_instr, ifid.if_pc);
        end
        tests++;
        if ({fetch_done, fetch_fault, fault_pc, instr_count, imem_addr} !== 104'h0) begin
            fails++;
            $display("FAIL reset_status: got d=%b f=%b fpc=%h cnt=%h a=%h want 0",
                     fetch_done, fetch_fault, fault_pc, instr_count, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'h8b1f03e0;
        exp_i[1] = 32'h8b1f0001;
        exp_i[2] = 32'h8b1f0022;
        exp_i[3] = 32'h8b1f0043;
        restart();
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (!ifid.if_valid || ifid.if_pc !== 64'(4*i) || ifid.if_instr !== exp_i[i]) begin
                fails++;
                $display("FAIL seq_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         i, ifid.if_valid, ifid.if_pc, ifid.if_instr, 4*i, exp_i[i]);
            end
        end
        fetch_en = 1'b0;
        step();
        tests++;
        if (instr_count !== 32'd4 || ifid.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL seq_count: got cnt=%0d v=%b want cnt=4 v=0",
                     instr_count, ifid.if_valid);
        end
    endtask

    task automatic test_stall();
        restart();
        step();
        step();
        ifid.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (!ifid.if_valid || ifid.if_pc !== 64'h4 ||
                ifid.if_instr !== 32'h8b1f0001 || imem_addr !== 6'd2) begin
                fails++;
                $display("FAIL stall_%0d: got v=%b pc=%h i=%h a=%0d want v=1 pc=4 i=8b1f0001 a=2",
                         i, ifid.if_valid, ifid.if_pc, ifid.if_instr, imem_addr);
            end
        end
        ifid.if_ready = 1'b1;
        step();
        tests++;
        if (!ifid.if_valid || ifid.if_pc !== 64'h8 || ifid.if_instr !== 32'h8b1f0022) begin
            fails++;
            $display("FAIL stall_resume: got v=%b pc=%h i=%h want v=1 pc=8 i=8b1f0022",
                     ifid.if_valid, ifid.if_pc, ifid.if_instr);
        end
        step();
        tests++;
        if (ifid.if_pc !== 64'hc || instr_count !== 32'd3) begin
            fails++;
            $display("FAIL stall_next: got pc=%h cnt=%0d want pc=c cnt=3",
                     ifid.if_pc, instr_count);
        end
    endtask

    task automatic test_redirect();
        restart();
        step();
        step();
        ifid.if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h10;
        step();
        redirect_valid = 1'b0;
        ifid.if_ready = 1'b1;
        tests++;
        if (ifid.if_valid !== 1'b0 || instr_count !== 32'd1) begin
            fails++;
            $display("FAIL redir_flush: got v=%b cnt=%0d want v=0 cnt=1",
                     ifid.if_valid, instr_count);
        end
        step();
        tests++;
        if (!ifid.if_valid || ifid.if_pc !== 64'h10 || ifid.if_instr !== 32'hf8000000) begin
            fails++;
            $display("FAIL redir_target: got v=%b pc=%h i=%h want v=1 pc=10 i=f8000000",
                     ifid.if_valid, ifid.if_pc, ifid.if_instr);
        end
    endtask

    task automatic test_done();
        int bad = 0;
        restart();
        for (int i = 0; i < 19; i++) begin
            step();
            if (!ifid.if_valid || ifid.if_pc !== 64'(4*i) || fetch_done) bad++;
        end
        tests++;
        if (bad != 0 || ifid.if_pc !== 64'h48) begin
            fails++;
            $display("FAIL done_run: got bad=%0d last_pc=%h want bad=0 last_pc=48",
                     bad, ifid.if_pc);
        end
        step();
        step();
        tests++;
        if (fetch_done !== 1'b1 || ifid.if_valid !== 1'b0 || instr_count !== 32'd19) begin
            fails++;
            $display("FAIL done_state: got d=%b v=%b cnt=%0d want d=1 v=0 cnt=19",
                     fetch_done, ifid.if_valid, instr_count);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (fetch_done !== 1'b0 || ifid.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_exit: got d=%b v=%b want d=0 v=0",
                     fetch_done, ifid.if_valid);
        end
        step();
        tests++;
        if (!ifid.if_valid || ifid.if_pc !== 64'h0 || ifid.if_instr !== 32'h8b1f03e0) begin
            fails++;
            $display("FAIL done_restart: got v=%b pc=%h i=%h want v=1 pc=0 i=8b1f03e0",
                     ifid.if_valid, ifid.if_pc, ifid.if_instr);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 64'h6;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        tests++;
        if (fetch_fault !== 1'b1 || fault_pc !== 64'h6 || ifid.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL fault_enter: got f=%b fpc=%h v=%b want f=1 fpc=6 v=0",
                     fetch_fault, fault_pc, ifid.if_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        step();
        tests++;
        if (fetch_fault !== 1'b1 || fault_pc !== 64'h6 || ifid.if_valid !== 1'b0) begin
            fails++;
            $display("FAIL fault_sticky: got f=%b fpc=%h v=%b want f=1 fpc=6 v=0",
                     fetch_fault, fault_pc, ifid.if_valid);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (fetch_fault !== 1'b0 || fault_pc !== 64'h0) begin
            fails++;
            $display("FAIL fault_reset: got f=%b fpc=%h want f=0 fpc=0",
                     fetch_fault, fault_pc);
        end
    endtask

    task automatic test_async_reset();
        restart();
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (ifid.if_valid !== 1'b0 || ifid.if_pc !== 64'h0 || ifid.if_instr !== 32'h0 ||
            instr_count !== 32'd0 || imem_addr !== 6'd0) begin
            fails++;
            $display("FAIL async_reset: got v=%b pc=%h i=%h cnt=%0d a=%0d want all 0",
                     ifid.if_valid, ifid.if_pc, ifid.if_instr, instr_count, imem_addr);
        end
        step();
        reset = 1'b1;
        step();
        tests++;
        if (!ifid.if_valid || ifid.if_pc !== 64'h0 || ifid.if_instr !== 32'h8b1f03e0) begin
            fails++;
            $display("FAIL async_restart: got v=%b pc=%h i=%h want v=1 pc=0 i=8b1f03e0",
                     ifid.if_valid, ifid.if_pc, ifid.if_instr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hdead0000 | 32'(i);
        rom[0] = 32'h8b1f03e0;
        rom[1] = 32'h8b1f0001;
        rom[2] = 32'h8b1f0022;
        rom[3] = 32'h8b1f0043;
        rom[4] = 32'hf8000000;
        ifid.if_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_done();
        test_fault();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
